// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the CPU datapath
// and a HOST (loader/debug) port. CPU has priority, and a streak counter
// guarantees the HOST a grant after HOST_STARVE back-to-back CPU grants.
//
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   cpu_req/we/addr/wdata          CPU request (held until cpu_ack)
//   cpu_ack, cpu_rdata             CPU completion pulse, read data (held)
//   host_req/we/addr/wdata         HOST request (held until host_ack)
//   host_ack, host_rdata           HOST completion pulse, read data (held)
//   mem_en/we/addr/wdata           memory strobe and latched access fields
//   mem_rdata                      memory read data, MEM_LAT cycles after mem_en
//   busy                           high whenever the FSM is not idle
//   owner                          0 = CPU, 1 = HOST for current/last grant
module mem_port_arbiter #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned MEM_LAT     = 1,
    parameter int unsigned HOST_STARVE = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // MEM_LAT is 1..4, so a 2-bit counter of elapsed wait cycles suffices.
    localparam int unsigned CNT_W = 2;
    localparam int unsigned STK_W = (HOST_STARVE < 1) ? 1 : $clog2(HOST_STARVE + 1);
    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(MEM_LAT - 1);
    localparam logic [STK_W-1:0] STK_MAX  = STK_W'(HOST_STARVE);

    logic [1:0]        state_q,      state_d;
    logic              we_q,         we_d;
    logic [ADDR_W-1:0] addr_q,       addr_d;
    logic [DATA_W-1:0] wdata_q,      wdata_d;
    logic              owner_q,      owner_d;
    logic [STK_W-1:0]  streak_q,     streak_d;
    logic [CNT_W-1:0]  lat_cnt_q,    lat_cnt_d;
    logic              mem_en_q,     mem_en_d;
    logic              cpu_ack_q,    cpu_ack_d;
    logic              host_ack_q,   host_ack_d;
    logic [DATA_W-1:0] cpu_rdata_q,  cpu_rdata_d;
    logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
    logic              busy_q,       busy_d;
    logic              grant_host;

    // Next-state, arbitration and registered-output logic.
    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        owner_d      = owner_q;
        streak_d     = streak_q;
        lat_cnt_d    = lat_cnt_q;
        mem_en_d     = 1'b0;
        cpu_ack_d    = 1'b0;
        host_ack_d   = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        host_rdata_d = host_rdata_q;
        grant_host   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!host_req) begin
                    streak_d = '0;
                end
                if (cpu_req || host_req) begin
                    // HOST wins when alone, or when the CPU streak has hit the guard.
                    grant_host = host_req &&
                                 (!cpu_req || ((HOST_STARVE != 0) && (streak_q == STK_MAX)));
                    if (grant_host) begin
                        we_d     = host_we;
                        addr_d   = host_addr;
                        wdata_d  = host_wdata;
                        owner_d  = 1'b1;
                        streak_d = '0;
                    end else begin
                        we_d    = cpu_we;
                        addr_d  = cpu_addr;
                        wdata_d = cpu_wdata;
                        owner_d = 1'b0;
                        if (host_req && (streak_q != STK_MAX)) begin
                            streak_d = streak_q + 1'b1;
                        end
                    end
                    mem_en_d = 1'b1;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                lat_cnt_d = '0;
                if (we_q) begin
                    state_d    = ST_RESP;
                    cpu_ack_d  = !owner_q;
                    host_ack_d = owner_q;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (lat_cnt_q == LAT_LAST) begin
                    // Last wait cycle: mem_rdata is valid now.
                    if (owner_q) begin
                        host_rdata_d = mem_rdata;
                    end else begin
                        cpu_rdata_d = mem_rdata;
                    end
                    state_d    = ST_RESP;
                    cpu_ack_d  = !owner_q;
                    host_ack_d = owner_q;
                end else begin
                    lat_cnt_d = lat_cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            owner_q      <= 1'b0;
            streak_q     <= '0;
            lat_cnt_q    <= '0;
            mem_en_q     <= 1'b0;
            cpu_ack_q    <= 1'b0;
            host_ack_q   <= 1'b0;
            cpu_rdata_q  <= '0;
            host_rdata_q <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            owner_q      <= owner_d;
            streak_q     <= streak_d;
            lat_cnt_q    <= lat_cnt_d;
            mem_en_q     <= mem_en_d;
            cpu_ack_q    <= cpu_ack_d;
            host_ack_q   <= host_ack_d;
            cpu_rdata_q  <= cpu_rdata_d;
            host_rdata_q <= host_rdata_d;
            busy_q       <= busy_d;
        end
    end

    assign cpu_ack    = cpu_ack_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign host_ack   = host_ack_q;
    assign host_rdata = host_rdata_q;
    assign mem_en     = mem_en_q;
    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign busy       = busy_q;
    assign owner      = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: one instance with MEM_LAT=1 for the transaction
// table, arbitration, reset and latching sequences, and one with MEM_LAT=3 for
// the long-latency read. Both share a behavioural memory.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance 1 (MEM_LAT=1)
    logic        c_req, c_we, h_req, h_we;
    logic [7:0]  c_addr, h_addr;
    logic [15:0] c_wdata, h_wdata;
    logic        cpu_ack, host_ack, mem_en, mem_we, busy, owner;
    logic [15:0] cpu_rdata, host_rdata, mem_wdata, mem_rdata;
    logic [7:0]  mem_addr;

    // Instance 3 (MEM_LAT=3)
    logic        c3_req, c3_we, h3_req, h3_we;
    logic [7:0]  c3_addr, h3_addr;
    logic [15:0] c3_wdata, h3_wdata;
    logic        cpu_ack3, host_ack3, mem_en3, mem_we3, busy3, owner3;
    logic [15:0] cpu_rdata3, host_rdata3, mem_wdata3, mem_rdata3;
    logic [7:0]  mem_addr3;

    mem_port_arbiter #(.DATA_W(16), .ADDR_W(8), .MEM_LAT(1), .HOST_STARVE(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(c_req), .cpu_we(c_we), .cpu_addr(c_addr), .cpu_wdata(c_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .host_req(h_req), .host_we(h_we), .host_addr(h_addr), .host_wdata(h_wdata),
        .host_ack(host_ack), .host_rdata(host_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
    );

    mem_port_arbiter #(.DATA_W(16), .ADDR_W(8), .MEM_LAT(3), .HOST_STARVE(4)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(c3_req), .cpu_we(c3_we), .cpu_addr(c3_addr), .cpu_wdata(c3_wdata),
        .cpu_ack(cpu_ack3), .cpu_rdata(cpu_rdata3),
        .host_req(h3_req), .host_we(h3_we), .host_addr(h3_addr), .host_wdata(h3_wdata),
        .host_ack(host_ack3), .host_rdata(host_rdata3),
        .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
        .mem_rdata(mem_rdata3), .busy(busy3), .owner(owner3)
    );

    // Behavioural memory; read data is only valid in the exact latency cycle,
    // otherwise a poison value is presented.
    logic [15:0] mem [256];
    logic [15:0] pipe1;
    logic [15:0] pipe3 [3];

    always @(posedge clk) begin
        if (mem_en && mem_we)   mem[mem_addr]  <= mem_wdata;
        if (mem_en3 && mem_we3) mem[mem_addr3] <= mem_wdata3;
        pipe1    <= (mem_en && !mem_we)   ? mem[mem_addr]  : 16'hDEAD;
        pipe3[0] <= (mem_en3 && !mem_we3) ? mem[mem_addr3] : 16'hDEAD;
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign mem_rdata  = pipe1;
    assign mem_rdata3 = pipe3[2];

    typedef struct packed {
        logic        men;
        logic        mwe;
        logic [7:0]  maddr;
        logic [15:0] mwd;
        logic        cack;
        logic        hack;
        logic [15:0] crd;
        logic [15:0] hrd;
        logic        own;
        logic        bsy;
    } snap_t;

    typedef struct {
        logic        host;
        logic        we;
        logic [7:0]  addr;
        logic [15:0] wdata;
        int          exp_lat;
        logic [15:0] exp_rd;
        string       name;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic snap_t snap(input int d);
        snap_t s;
        if (d == 3)
            s = snap_t'({mem_en3, mem_we3, mem_addr3, mem_wdata3, cpu_ack3, host_ack3,
                         cpu_rdata3, host_rdata3, owner3, busy3});
        else
            s = snap_t'({mem_en, mem_we, mem_addr, mem_wdata, cpu_ack, host_ack,
                         cpu_rdata, host_rdata, owner, busy});
        return s;
    endfunction

    task automatic drive(input int d, input logic host, input logic req, input logic we,
                         input logic [7:0] addr, input logic [15:0] wdata);
        if (d == 3) begin
            if (host) begin h3_req = req; h3_we = we; h3_addr = addr; h3_wdata = wdata; end
            else      begin c3_req = req; c3_we = we; c3_addr = addr; c3_wdata = wdata; end
        end else begin
            if (host) begin h_req = req; h_we = we; h_addr = addr; h_wdata = wdata; end
            else      begin c_req = req; c_we = we; c_addr = addr; c_wdata = wdata; end
        end
    endtask

    // One transaction starting in an IDLE cycle (cycle 0 = request cycle).
    // lat = cycle of ack (0 if none), en_at = cycle of mem_en, s_en/s_ack = snapshots.
    task automatic xfer(input int d, input logic host, input logic we, input logic [7:0] addr,
                        input logic [15:0] wdata, output int lat, output int en_at,
                        output snap_t s_en, output snap_t s_ack);
        snap_t s;
        @(negedge clk);
        drive(d, host, 1'b1, we, addr, wdata);
        lat = 0; en_at = 0; s_en = '0; s_ack = '0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            s = snap(d);
            if (s.men && en_at == 0) begin en_at = k; s_en = s; end
            if ((host && s.hack) || (!host && s.cack)) begin lat = k; s_ack = s; break; end
        end
        drive(d, host, 1'b0, we, addr, wdata);
    endtask

    vec_t        vecs [10];
    logic [15:0] exp_crd, exp_hrd;
    int          lat, en_at, n, cack_at, hack_at;
    logic        own1, own2;
    logic        glog [10];
    snap_t       s, s_en, s_ack;

    initial begin
        vecs[0] = '{1'b0, 1'b1, 8'h12, 16'hBEEF, 2, 16'h0000, "cpu_wr_12"};
        vecs[1] = '{1'b0, 1'b0, 8'h12, 16'h0000, 3, 16'hBEEF, "cpu_rd_12"};
        vecs[2] = '{1'b1, 1'b1, 8'h34, 16'h1234, 2, 16'h0000, "host_wr_34"};
        vecs[3] = '{1'b1, 1'b0, 8'h34, 16'h0000, 3, 16'h1234, "host_rd_34"};
        vecs[4] = '{1'b0, 1'b0, 8'h34, 16'h0000, 3, 16'h1234, "cpu_rd_34"};
        vecs[5] = '{1'b0, 1'b1, 8'hFF, 16'hA5A5, 2, 16'h0000, "cpu_wr_ff"};
        vecs[6] = '{1'b0, 1'b0, 8'hFF, 16'h0000, 3, 16'hA5A5, "cpu_rd_ff"};
        vecs[7] = '{1'b1, 1'b0, 8'h12, 16'h0000, 3, 16'hBEEF, "host_rd_12"};
        vecs[8] = '{1'b1, 1'b1, 8'h00, 16'h0000, 2, 16'h0000, "host_wr_00"};
        vecs[9] = '{1'b1, 1'b0, 8'h00, 16'h0000, 3, 16'h0000, "host_rd_00"};

        rst_n = 1'b0;
        c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
        h_req = 0; h_we = 0; h_addr = 0; h_wdata = 0;
        c3_req = 0; c3_we = 0; c3_addr = 0; c3_wdata = 0;
        h3_req = 0; h3_we = 0; h3_addr = 0; h3_wdata = 0;
        repeat (3) @(negedge clk);

        // Reset state: every output zero on both instances.
        check("reset_ctl", 32'({cpu_ack, host_ack, mem_en, mem_we, busy, owner, mem_addr}), 32'h0);
        check("reset_rd",  {cpu_rdata, host_rdata}, 32'h0);
        check("reset_wd",  32'(mem_wdata), 32'h0);
        check("reset3_ctl", 32'({cpu_ack3, host_ack3, mem_en3, mem_we3, busy3, owner3, mem_addr3}), 32'h0);
        rst_n = 1'b1;

        // Transaction table on the MEM_LAT=1 instance.
        exp_crd = 16'h0;
        exp_hrd = 16'h0;
        for (int i = 0; i < 10; i++) begin
            xfer(1, vecs[i].host, vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, en_at, s_en, s_ack);
            if (!vecs[i].we) begin
                if (vecs[i].host) exp_hrd = vecs[i].exp_rd;
                else              exp_crd = vecs[i].exp_rd;
            end
            check({vecs[i].name, "_lat"},   lat, vecs[i].exp_lat);
            check({vecs[i].name, "_en"},    en_at, 1);
            check({vecs[i].name, "_maddr"}, 32'(s_en.maddr), 32'(vecs[i].addr));
            check({vecs[i].name, "_mwe"},   32'(s_en.mwe), 32'(vecs[i].we));
            check({vecs[i].name, "_mwd"},   32'(s_en.mwd), 32'(vecs[i].wdata));
            check({vecs[i].name, "_crd"},   32'(s_ack.crd), 32'(exp_crd));
            check({vecs[i].name, "_hrd"},   32'(s_ack.hrd), 32'(exp_hrd));
            check({vecs[i].name, "_own"},   32'(s_ack.own), 32'(vecs[i].host));
            check({vecs[i].name, "_busy"},  32'(s_ack.bsy), 32'h1);
            check({vecs[i].name, "_xack"},  32'(vecs[i].host ? s_ack.cack : s_ack.hack), 32'h0);
        end

        // Simultaneous requests: CPU first, HOST in the following IDLE cycle.
        @(negedge clk);
        drive(1, 1'b0, 1'b1, 1'b1, 8'h70, 16'h1111);
        drive(1, 1'b1, 1'b1, 1'b1, 8'h71, 16'h2222);
        cack_at = 0; hack_at = 0; own1 = 1'bx; own2 = 1'bx; n = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            s = snap(1);
            if (s.men) begin
                if (n == 0) own1 = s.own; else own2 = s.own;
                n++;
            end
            if (s.cack) begin cack_at = k; c_req = 1'b0; end
            if (s.hack) begin hack_at = k; h_req = 1'b0; break; end
        end
        check("both_cack_at", cack_at, 2);
        check("both_hack_at", hack_at, 5);
        check("both_own1", 32'(own1), 32'h0);
        check("both_own2", 32'(own2), 32'h1);

        // Starvation guard: CPU re-requests continuously, HOST held high.
        @(negedge clk);
        drive(1, 1'b0, 1'b1, 1'b1, 8'h50, 16'h5050);
        drive(1, 1'b1, 1'b1, 1'b1, 8'h60, 16'h6060);
        n = 0;
        for (int k = 0; k < 80 && n < 10; k++) begin
            @(negedge clk);
            s = snap(1);
            if (s.men) begin glog[n] = s.own; n++; end
        end
        c_req = 1'b0;
        h_req = 1'b0;
        repeat (4) @(negedge clk);
        check("starve_count", n, 10);
        for (int i = 0; i < 10; i++)
            check($sformatf("starve_grant%0d", i), 32'(glog[i]), (i == 4 || i == 9) ? 32'h1 : 32'h0);

        // MEM_LAT=3: HOST preload then read back.
        xfer(3, 1'b1, 1'b1, 8'h40, 16'h5A5A, lat, en_at, s_en, s_ack);
        check("lat3_wr_lat", lat, 2);
        xfer(3, 1'b1, 1'b0, 8'h40, 16'h0000, lat, en_at, s_en, s_ack);
        check("lat3_rd_lat", lat, 5);
        check("lat3_rd_en",  en_at, 1);
        check("lat3_rd_data", 32'(s_ack.hrd), 32'h5A5A);
        check("lat3_crd",     32'(s_ack.crd), 32'h0);

        // Reset during WAIT of a CPU read.
        @(negedge clk);
        drive(1, 1'b0, 1'b1, 1'b0, 8'h12, 16'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        c_req = 1'b0;
        #1;
        check("rst_wait_ctl", 32'({cpu_ack, host_ack, mem_en, mem_we, busy, owner, mem_addr}), 32'h0);
        check("rst_wait_rd",  {cpu_rdata, host_rdata}, 32'h0);
        check("rst_wait_wd",  32'(mem_wdata), 32'h0);
        @(negedge clk);
        check("rst_hold_ack", 32'(cpu_ack), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_after_ack",  32'(cpu_ack), 32'h0);
        check("rst_after_busy", 32'(busy), 32'h0);
        xfer(1, 1'b0, 1'b0, 8'h12, 16'h0, lat, en_at, s_en, s_ack);
        check("rst_reissue_lat", lat, 3);
        check("rst_reissue_rd",  32'(s_ack.crd), 32'hBEEF);

        // Request fields changed after grant are ignored.
        @(negedge clk);
        drive(1, 1'b0, 1'b1, 1'b1, 8'h21, 16'h7777);
        @(negedge clk);
        s = snap(1);
        check("latch_en",    32'(s.men), 32'h1);
        check("latch_addr0", 32'(s.maddr), 32'h21);
        drive(1, 1'b0, 1'b1, 1'b0, 8'h22, 16'h8888);
        @(negedge clk);
        s = snap(1);
        check("latch_ack",   32'(s.cack), 32'h1);
        check("latch_addr1", 32'(s.maddr), 32'h21);
        check("latch_we1",   32'(s.mwe), 32'h1);
        check("latch_wd1",   32'(s.mwd), 32'h7777);
        c_req = 1'b0;
        xfer(1, 1'b0, 1'b0, 8'h21, 16'h0, lat, en_at, s_en, s_ack);
        check("latch_rd_lat",  lat, 3);
        check("latch_rd_data", 32'(s_ack.crd), 32'h7777);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
